// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous prefetch FIFO with clear; head entry is read combinationally.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;

  // Storage is intentionally left unreset; only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: single-outstanding memory request FSM feeding a
// prefetch FIFO, with redirect flush and discard of in-flight data.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic                    imem_ack,
  input  logic [WORD_W-1:0]       imem_rdata,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    inst_valid,
  output logic [WORD_W-1:0]       inst,
  output logic [ADDR_W-1:0]       inst_pc,
  input  logic                    inst_ready,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              run_q;
  logic              ack, push, pop, room_now, room_after_push;
  logic [ADDR_W-1:0] redir_pc;
  fetch_entry_t      wr_entry, head;

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = addr_q;
  assign ack       = imem_ack & imem_req;
  assign push      = ack & (state_q == S_REQ) & ~redirect_valid;
  assign pop       = inst_valid & inst_ready & ~redirect_valid;
  assign redir_pc  = redirect_pc & ~ADDR_W'(3);

  // Space rule: the next ack must always find a free slot.
  assign room_now        = count < CW'(DEPTH);
  assign room_after_push = (count + CW'(1)) < CW'(DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          state_d    = S_REQ;
          fetch_pc_d = redir_pc;
          addr_d     = redir_pc;
        end else if (run_q && room_now) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          if (ack) addr_d = redir_pc;
          else     state_d = S_DROP;
        end else if (ack) begin
          fetch_pc_d = addr_q + ADDR_W'(4);
          if (room_after_push) addr_d = addr_q + ADDR_W'(4);
          else                 state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          if (ack) begin
            state_d = S_REQ;
            addr_d  = redir_pc;
          end
        end else if (ack) begin
          if (room_now) begin
            state_d = S_REQ;
            addr_d  = fetch_pc_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // run_q holds off the first fetch one cycle so release is seen synchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      run_q      <= 1'b1;
    end
  end

  assign wr_entry = '{data: imem_rdata, pc: addr_q};

  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .din_i   (wr_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.data;
  assign inst_pc    = head.pc;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: queue-based reference model plus directed scenarios.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req, imem_ack, redirect_valid, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [2:0]  count;

  logic        b_req, b_valid;
  logic [31:0] b_addr, b_inst, b_pc;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Memory: mode 0 zero-wait, mode 1 fixed latency, mode 2 random ack
  int   mode = 0;
  int   lat  = 0;
  logic rnd_ack = 1'b0;
  int   wcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  always_comb begin
    imem_ack = 1'b0;
    if (imem_req) begin
      if (mode == 0)      imem_ack = 1'b1;
      else if (mode == 1) imem_ack = (wcnt >= lat);
      else                imem_ack = rnd_ack;
    end
  end
  assign imem_rdata = memf(imem_addr);

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .count(count)
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_req), .imem_rdata(memf(b_addr)), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .inst_valid(b_valid), .inst(b_inst), .inst_pc(b_pc),
    .inst_ready(1'b1), .count(b_count)
  );

  // Reference model: one outstanding request, queue of fetched entries
  typedef struct packed { logic [31:0] d; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  ent_t        me;
  bit          m_pend, m_drop, m_run, mk_ack, mk_pop;
  int          mk_occ;
  logic [31:0] m_addr, m_fpc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_pend = 0; m_drop = 0; m_run = 0;
      m_addr = 32'h0; m_fpc = 32'h0;
    end else begin
      mk_ack = imem_ack && m_pend;
      mk_pop = (mq.size() != 0) && inst_ready;
      if (redirect_valid) begin
        mq.delete();
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
        if (!m_pend || mk_ack) begin m_pend = 1; m_drop = 0; m_addr = m_fpc; end
        else m_drop = 1;
      end else begin
        if (mk_ack && !m_drop) begin
          me.d = memf(m_addr); me.pc = m_addr;
          mq.push_back(me);
          m_fpc = m_addr + 32'd4;
        end
        mk_occ = mq.size();
        if (mk_pop) void'(mq.pop_front());
        if (mk_ack || !m_pend) begin
          m_drop = 0;
          if (m_run && mk_occ < DEPTH) begin m_pend = 1; m_addr = m_fpc; end
          else m_pend = 0;
        end
      end
      m_run = 1;
    end
  end

  always @(negedge clk) begin
    chk("req", imem_req, m_pend);
    if (m_pend) chk("addr", imem_addr, m_addr);
    chk("count", 32'(count), mq.size());
    chk("valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("inst", inst, mq[0].d);
      chk("inst_pc", inst_pc, mq[0].pc);
    end
  end

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  logic [31:0] bexp [3];
  int k, kb, n;

  initial begin
    bexp[0] = 32'hFFFF_FFF8; bexp[1] = 32'hFFFF_FFFC; bexp[2] = 32'h0000_0000;
    inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_addr_b", b_addr, 32'hFFFF_FFF8);
    rst = 1'b1;
    @(negedge clk); chk("req_edge1", imem_req, 1'b0);
    @(negedge clk); chk("req_edge2", imem_req, 1'b1); chk("first_addr", imem_addr, 32'h0);

    // Zero-wait streaming and 32-bit PC wrap
    k = 0; kb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((k > 0 || inst_valid) && k < 8) begin
        chk("seq_valid", inst_valid, 1'b1);
        chk("seq_pc", inst_pc, 32'(4 * k));
        chk("seq_inst", inst, memf(32'(4 * k)));
        k++;
      end
      if (b_valid && kb < 3) begin chk("wrap_pc", b_pc, bexp[kb]); kb++; end
    end
    chk("seq_len", k, 8);
    chk("wrap_len", kb, 3);

    // Backpressure: fill to DEPTH and stop requesting
    inst_ready = 1'b0;
    pulse_redirect(32'h0);
    repeat (15) @(negedge clk);
    chk("full_count", 32'(count), 4);
    chk("full_req", imem_req, 1'b0);
    chk("full_head_pc", inst_pc, 32'h0);
    chk("full_head_inst", inst, 32'hA5A5_0000);

    // Redirect during outstanding request with latency
    mode = 1; lat = 3; inst_ready = 1'b1;
    pulse_redirect(32'h0);
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 200) begin @(negedge clk); n++; end
    chk("wait_req08", n < 200, 1'b1);
    @(negedge clk);
    pulse_redirect(32'h0000_0040);
    n = 0;
    while (!(imem_req && imem_addr != 32'h8) && n < 200) begin @(negedge clk); n++; end
    chk("drop_next_addr", imem_addr, 32'h40);
    n = 0;
    while (!inst_valid && n < 200) begin @(negedge clk); n++; end
    chk("drop_first_pc", inst_pc, 32'h40);

    // Redirect coincident with ack
    lat = 2;
    pulse_redirect(32'h0);
    n = 0;
    while (!(imem_req && imem_ack && imem_addr == 32'h10) && n < 200) begin @(negedge clk); n++; end
    chk("wait_ack10", n < 200, 1'b1);
    pulse_redirect(32'h0000_0103);
    chk("coinc_count", 32'(count), 0);
    chk("coinc_valid", inst_valid, 1'b0);
    chk("coinc_req", imem_req, 1'b1);
    chk("coinc_addr", imem_addr, 32'h100);
    n = 0;
    while (!inst_valid && n < 200) begin @(negedge clk); n++; end
    chk("coinc_first_pc", inst_pc, 32'h100);

    // Asynchronous reset mid-request
    inst_ready = 1'b0;
    pulse_redirect(32'h0);
    n = 0;
    while (!(count == 3'd2 && imem_req) && n < 200) begin @(negedge clk); n++; end
    chk("wait_cnt2", n < 200, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_count", 32'(count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1; inst_ready = 1'b1;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    chk("arst_first_addr", imem_addr, 32'h0);

    // Random traffic against the model
    mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rnd_ack        = ($urandom_range(0, 2) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
